// File: rtl/seq_divider.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per Run-enabled
// clock. Operands are captured on the start edge and the result is published on DONE entry.
module seq_divider (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        Ready,
    output logic        DivZero,
    output logic [1:0]  o_dbg_state
);

    // Handshake: Run high while IDLE starts an operation. Run low while CALC
    // stalls the iteration. The result is held while Ready=1. Ready drops on
    // the first edge that sees Run low in DONE, which returns the block to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic [5:0]  r_cnt, w_cnt_nx;
    logic [31:0] r_hi, w_hi_nx;
    logic [31:0] r_lo, w_lo_nx;
    logic [31:0] r_dvs, w_dvs_nx;
    logic [31:0] r_quot, w_quot_nx;
    logic [31:0] r_rem, w_rem_nx;
    logic        r_ready, w_ready_nx;
    logic        r_divzero, w_divzero_nx;

    logic [31:0] w_hi_sh;
    logic [32:0] w_trial;
    logic        w_borrow;
    logic [31:0] w_hi_iter;
    logic [31:0] w_lo_iter;

    // Before the last iteration the partial remainder is below 2^31, so a
    // 32-bit shifted value loses nothing.
    assign w_hi_sh   = {r_hi[30:0], r_lo[31]};
    assign w_trial   = {1'b0, w_hi_sh} - {1'b0, r_dvs};
    assign w_borrow  = w_trial[32];
    assign w_hi_iter = w_borrow ? w_hi_sh : w_trial[31:0];
    assign w_lo_iter = {r_lo[30:0], ~w_borrow};

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_hi_nx      = r_hi;
        w_lo_nx      = r_lo;
        w_dvs_nx     = r_dvs;
        w_quot_nx    = r_quot;
        w_rem_nx     = r_rem;
        w_ready_nx   = r_ready;
        w_divzero_nx = r_divzero;

        case (r_state)
            IDLE: begin
                if (Run) begin
                    if (Divisor == 32'd0) begin
                        w_state_nx   = DONE;
                        w_quot_nx    = 32'hFFFF_FFFF;
                        w_rem_nx     = Dividend;
                        w_ready_nx   = 1'b1;
                        w_divzero_nx = 1'b1;
                    end else begin
                        w_state_nx = CALC;
                        w_dvs_nx   = Divisor;
                        w_hi_nx    = 32'd0;
                        w_lo_nx    = Dividend;
                        w_cnt_nx   = 6'd0;
                    end
                end
            end

            CALC: begin
                if (Run) begin
                    w_hi_nx  = w_hi_iter;
                    w_lo_nx  = w_lo_iter;
                    w_cnt_nx = r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        w_state_nx   = DONE;
                        w_quot_nx    = w_lo_iter;
                        w_rem_nx     = w_hi_iter;
                        w_ready_nx   = 1'b1;
                        w_divzero_nx = 1'b0;
                    end
                end
            end

            DONE: begin
                if (!Run) begin
                    w_state_nx   = IDLE;
                    w_ready_nx   = 1'b0;
                    w_divzero_nx = 1'b0;
                end
            end

            default: begin
                w_state_nx   = IDLE;
                w_ready_nx   = 1'b0;
                w_divzero_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= 6'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_dvs     <= 32'd0;
            r_quot    <= 32'd0;
            r_rem     <= 32'd0;
            r_ready   <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_hi      <= w_hi_nx;
            r_lo      <= w_lo_nx;
            r_dvs     <= w_dvs_nx;
            r_quot    <= w_quot_nx;
            r_rem     <= w_rem_nx;
            r_ready   <= w_ready_nx;
            r_divzero <= w_divzero_nx;
        end
    end

    assign Quotient    = r_quot;
    assign Remainder   = r_rem;
    assign Ready       = r_ready;
    assign DivZero     = r_divzero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table plus reset and stall sequences,
// with expected results queued at start and checked when Ready rises.
module tb_seq_divider;

    logic        clk;
    logic        Reset;
    logic        Run;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Ready;
    logic        DivZero;
    logic [1:0]  o_dbg_state;

    seq_divider dut (
        .clk         (clk),
        .Reset       (Reset),
        .Run         (Run),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Ready       (Ready),
        .DivZero     (DivZero),
        .o_dbg_state (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          stall_at;
        int          stall_len;
        bit          scramble;
    } vec_t;

    vec_t        vecs[13];
    logic [64:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [31:0] r, input logic dz,
                                input int sa, input int sl, input bit sc);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
        v.stall_at = sa; v.stall_len = sl; v.scramble = sc;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int          edge_n;
        int          exp_lat;
        bit          held_ok;
        logic [31:0] q0, r0;
        logic [64:0] e;

        exp_lat = (v.b == 32'd0) ? 1 : 33 + v.stall_len;
        @(negedge clk);
        q0 = Quotient;
        r0 = Remainder;
        Dividend = v.a;
        Divisor  = v.b;
        Run      = 1'b1;
        exp_q.push_back({v.dz, v.q, v.r});
        edge_n  = 0;
        held_ok = 1'b1;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (Ready) break;
            if (Quotient !== q0 || Remainder !== r0) held_ok = 1'b0;
            if (edge_n >= 100) begin
                check("timeout_ready", 64'(edge_n), 64'(exp_lat));
                break;
            end
            @(negedge clk);
            Run = !(v.stall_len > 0 && edge_n >= v.stall_at && edge_n < v.stall_at + v.stall_len);
            if (v.scramble) begin
                Dividend = $urandom;
                Divisor  = $urandom_range(0, 255);
            end
        end
        check("outputs_held_during_calc", 64'(held_ok), 64'd1);
        check("latency", 64'(edge_n), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("quotient", 64'(Quotient), 64'(e[63:32]));
            check("remainder", 64'(Remainder), 64'(e[31:0]));
            check("divzero", 64'(DivZero), 64'(e[64]));
        end
        // Run stays high in DONE: everything must hold even if operands move
        repeat (2) begin
            @(negedge clk);
            Run = 1'b1;
            Dividend = $urandom;
            Divisor  = $urandom;
            @(posedge clk);
            #1;
            check("done_hold", {30'd0, Ready, DivZero, Quotient}, {30'd0, 1'b1, v.dz, v.q});
        end
        @(negedge clk);
        Run = 1'b0;
        @(posedge clk);
        #1;
        check("ready_clear", {30'd0, Ready, DivZero, 30'd0, o_dbg_state}, 64'd0);
        check("retained", {Quotient, Remainder}, {v.q, v.r});
    endtask

    initial begin
        logic [31:0] ra, rb;

        vecs[0]  = mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 0, 1'b0);
        vecs[1]  = mk(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0, 1'b0);
        vecs[2]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0, 0, 1'b0);
        vecs[3]  = mk(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0, 1'b0);
        vecs[4]  = mk(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 11, 5, 1'b0);
        vecs[5]  = mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 0, 1'b1);
        vecs[6]  = mk(32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        vecs[7]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 0, 1'b0);
        for (int i = 8; i < 12; i++) begin
            ra = $urandom;
            rb = (i == 11) ? $urandom : 32'($urandom_range(1, 65535));
            if (rb == 32'd0) rb = 32'd1;
            vecs[i] = mk(ra, rb, ra / rb, ra % rb, 1'b0, 0, 0, 1'b0);
        end
        vecs[12] = mk(32'h1234_5678, 32'd1000, 32'h0004_A90B, 32'h0000_0380, 1'b0, 0, 0, 1'b0);

        // Reset held with Run high and a zero divisor must stay idle
        Reset    = 1'b1;
        Run      = 1'b1;
        Dividend = 32'd5;
        Divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {Quotient, Remainder}, 64'd0);
        check("reset_flags", {60'd0, Ready, DivZero, o_dbg_state}, 64'd0);
        @(negedge clk);
        Reset = 1'b0;
        Run   = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", {61'd0, Ready, o_dbg_state}, 64'd0);

        for (int i = 0; i < 13; i++) run_op(vecs[i]);

        // Abort 100/7 after iteration 16 with an asynchronous reset pulse
        @(negedge clk);
        Dividend = 32'd100;
        Divisor  = 32'd7;
        Run      = 1'b1;
        repeat (17) @(posedge clk);
        #2;
        check("mid_calc_state", 64'(o_dbg_state), 64'd1);
        Reset = 1'b1;
        #1;
        check("abort_outputs", {Quotient, Remainder}, 64'd0);
        check("abort_flags", {60'd0, Ready, DivZero, o_dbg_state}, 64'd0);
        @(posedge clk);
        #1;
        check("abort_held", {58'd0, Ready, DivZero, o_dbg_state, 2'd0}, 64'd0);
        @(negedge clk);
        Reset = 1'b0;
        Run   = 1'b0;
        run_op(mk(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 0, 0, 1'b0));

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
